// File: rtl/mvm_dot_accum_if.sv
// Beat/result bundle for mvm_dot_accum: aligned SRAM beats in, FIFO'd dot products out.
// slave = the datapath, master = the controller/SRAM/consumer side driving it.
interface mvm_dot_accum_if #(
  parameter int LANES      = 4,
  parameter int IWIDTH     = 8,
  parameter int OWIDTH     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                     beat_valid;
  logic                     accum_first;
  logic                     accum_last;
  logic [LANES*IWIDTH-1:0]  vec_rdata;
  logic [LANES*IWIDTH-1:0]  mat_rdata;
  logic signed [OWIDTH-1:0] result;
  logic                     result_valid;
  logic                     result_ready;
  logic [LW-1:0]            fifo_level;
  logic                     drop_err;
  logic                     busy;

  modport master (
    output beat_valid, accum_first, accum_last, vec_rdata, mat_rdata, result_ready,
    input  result, result_valid, fifo_level, drop_err, busy
  );

  modport slave (
    input  beat_valid, accum_first, accum_last, vec_rdata, mat_rdata, result_ready,
    output result, result_valid, fifo_level, drop_err, busy
  );
endinterface

// File: rtl/mvm_dot_accum.sv
// Dot-product accumulator behind the MVM controller: LANES MACs per beat, row accumulation, output FIFO.
// Define MVM_ACC_SAT_EN to saturate the accumulator to OWIDTH instead of wrapping.
module mvm_dot_accum #(
  parameter int LANES      = 4,
  parameter int IWIDTH     = 8,
  parameter int OWIDTH     = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  mvm_dot_accum_if.slave  bus
);
  localparam int PW   = 2 * IWIDTH;
  localparam int SUMW = PW + $clog2(LANES);
  localparam int AW   = ((OWIDTH > SUMW) ? OWIDTH : SUMW) + 1;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int LW   = PTRW + 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  // strobe alignment with SRAM read data
  logic al_valid, al_first, al_last, dly_busy;

  generate
    if (MEM_LAT == 0) begin : g_nodly
      assign al_valid = bus.beat_valid;
      assign al_first = bus.accum_first;
      assign al_last  = bus.accum_last;
      assign dly_busy = 1'b0;
    end else begin : g_dly
      logic [MEM_LAT-1:0] v_sr, f_sr, l_sr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_sr <= '0;
          f_sr <= '0;
          l_sr <= '0;
        end else begin
          v_sr[0] <= bus.beat_valid;
          f_sr[0] <= bus.accum_first;
          l_sr[0] <= bus.accum_last;
          for (int i = 1; i < MEM_LAT; i++) begin
            v_sr[i] <= v_sr[i-1];
            f_sr[i] <= f_sr[i-1];
            l_sr[i] <= l_sr[i-1];
          end
        end
      end

      assign al_valid = v_sr[MEM_LAT-1];
      assign al_first = f_sr[MEM_LAT-1];
      assign al_last  = l_sr[MEM_LAT-1];
      assign dly_busy = |v_sr;
    end
  endgenerate

  // stage A: lane products
  logic signed [PW-1:0] prod_c [LANES];
  logic signed [PW-1:0] prod_q [LANES];
  logic                 pa_valid, pa_first, pa_last;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = PW'($signed(bus.vec_rdata[i*IWIDTH +: IWIDTH]))
                * PW'($signed(bus.mat_rdata[i*IWIDTH +: IWIDTH]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_valid <= 1'b0;
      pa_first <= 1'b0;
      pa_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      pa_valid <= al_valid;
      pa_first <= al_first;
      pa_last  <= al_last;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_c[i];
    end
  end

  // stage B: reduce and accumulate
  logic signed [SUMW-1:0]   sum_c;
  logic signed [AW-1:0]     acc_wide;
  logic signed [OWIDTH-1:0] acc_next;
  logic signed [OWIDTH-1:0] acc_q;
  logic                     push;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) sum_c = sum_c + SUMW'(prod_q[i]);
  end

  always_comb begin
    acc_wide = pa_first ? AW'(sum_c) : (AW'(acc_q) + AW'(sum_c));
`ifdef MVM_ACC_SAT_EN
    if (acc_wide > SAT_MAX)
      acc_next = SAT_MAX[OWIDTH-1:0];
    else if (acc_wide < SAT_MIN)
      acc_next = SAT_MIN[OWIDTH-1:0];
    else
      acc_next = acc_wide[OWIDTH-1:0];
`else
    acc_next = acc_wide[OWIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc_q <= '0;
    else if (pa_valid)
      acc_q <= acc_next;
  end

  assign push = pa_valid & pa_last;

  // output FIFO
  logic signed [OWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTRW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]            count;
  logic                     full, empty, pop, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == LW'(FIFO_DEPTH));
  assign pop     = ~empty & bus.result_ready;
  // a full FIFO still takes a push when the consumer frees a slot in the same cycle
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= acc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      bus.drop_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)     rd_ptr <= rd_ptr + PTRW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) bus.drop_err <= 1'b1;
    end
  end

  assign bus.result       = empty ? '0 : mem[rd_ptr];
  assign bus.result_valid = ~empty;
  assign bus.fifo_level   = count;
  assign bus.busy         = dly_busy | pa_valid | ~empty;

endmodule

// File: tb/tb_mvm_dot_accum.sv
// Directed bench for mvm_dot_accum: default, FIFO_DEPTH=2 and OWIDTH=16 instances share one beat stream.
module tb_mvm_dot_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        bv, fst, lst;
  logic [31:0] vec_a, mat_a, vec_q, mat_q;
  logic        rdy0, rdy2, rdy16;

  int checks = 0;
  int errors = 0;

  // SRAM model: data follows the address strobes by one cycle
  always @(posedge clk) begin
    vec_q <= vec_a;
    mat_q <= mat_a;
  end

  mvm_dot_accum_if #(.OWIDTH(32), .FIFO_DEPTH(4)) i0 ();
  mvm_dot_accum_if #(.OWIDTH(32), .FIFO_DEPTH(2)) i2 ();
  mvm_dot_accum_if #(.OWIDTH(16), .FIFO_DEPTH(4)) i16 ();

  assign i0.beat_valid   = bv;  assign i0.accum_first  = fst; assign i0.accum_last  = lst;
  assign i0.vec_rdata    = vec_q; assign i0.mat_rdata  = mat_q; assign i0.result_ready = rdy0;
  assign i2.beat_valid   = bv;  assign i2.accum_first  = fst; assign i2.accum_last  = lst;
  assign i2.vec_rdata    = vec_q; assign i2.mat_rdata  = mat_q; assign i2.result_ready = rdy2;
  assign i16.beat_valid  = bv;  assign i16.accum_first = fst; assign i16.accum_last = lst;
  assign i16.vec_rdata   = vec_q; assign i16.mat_rdata = mat_q; assign i16.result_ready = rdy16;

  mvm_dot_accum #(.OWIDTH(32), .FIFO_DEPTH(4)) d0  (.clk(clk), .rst(rst), .bus(i0));
  mvm_dot_accum #(.OWIDTH(32), .FIFO_DEPTH(2)) d2  (.clk(clk), .rst(rst), .bus(i2));
  mvm_dot_accum #(.OWIDTH(16), .FIFO_DEPTH(4)) d16 (.clk(clk), .rst(rst), .bus(i16));

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l, input logic [31:0] v, input logic [31:0] m);
    bv = 1'b1; fst = f; lst = l; vec_a = v; mat_a = m;
    tick();
    bv = 1'b0; fst = 1'b0; lst = 1'b0;
  endtask

  task automatic do_reset();
    rdy0 = 1'b0; rdy2 = 1'b0; rdy16 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bv = 1'b0; fst = 1'b0; lst = 1'b0;
    vec_a = '0; mat_a = '0; rdy0 = 1'b0; rdy2 = 1'b0; rdy16 = 1'b0;
    tick(); tick();
    chk("rst_valid", i0.result_valid, 0);
    chk("rst_level", i0.fifo_level, 0);
    chk("rst_drop",  i0.drop_err, 0);
    chk("rst_busy",  i0.busy, 0);
    chk("rst_result", i0.result, 0);
    rst = 1'b0;
    tick();

    // single-chunk row, sum 10, valid at t+3
    beat(1, 1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    chk("t1_busy_t1", i0.busy, 1);
    tick();
    chk("t1_valid_t2", i0.result_valid, 0);
    tick();
    chk("t1_valid_t3", i0.result_valid, 1);
    chk("t1_result", i0.result, 10);
    chk("t1_level", i0.fifo_level, 1);
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    chk("t1_popped_valid", i0.result_valid, 0);
    chk("t1_popped_result", i0.result, 0);
    chk("t1_idle_busy", i0.busy, 0);

    // two-chunk row summing to 0, then a single-beat row with extreme operands
    do_reset();
    beat(1, 0, pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    beat(0, 1, pk(-1, -1, -1, -1), pk(5, 5, 5, 5));
    beat(1, 1, pk(-128, 0, 0, 0), pk(127, 0, 0, 0));
    tick();
    chk("t2_row0", i0.result, 0);
    chk("t2_level1", i0.fifo_level, 1);
    tick();
    chk("t2_level2", i0.fifo_level, 2);
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    chk("t2_row1", i0.result, -16256);
    chk("t2_level_after_pop", i0.fifo_level, 1);

    // bubble of three cycles mid-row
    do_reset();
    beat(1, 0, pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    tick(); tick(); tick();
    beat(0, 1, pk(1, 1, 1, 1), pk(1, 2, 0, 3));
    tick();
    chk("t3_valid_early", i0.result_valid, 0);
    tick();
    chk("t3_result", i0.result, 26);

    // overflow of the 2-deep FIFO with no consumer
    do_reset();
    beat(1, 1, pk(1, 0, 0, 0), pk(1, 0, 0, 0));
    beat(1, 1, pk(2, 0, 0, 0), pk(1, 0, 0, 0));
    beat(1, 1, pk(3, 0, 0, 0), pk(1, 0, 0, 0));
    tick(); tick();
    chk("t4_d2_level", i2.fifo_level, 2);
    chk("t4_d2_drop", i2.drop_err, 1);
    chk("t4_d2_head", i2.result, 1);
    chk("t4_d0_level", i0.fifo_level, 3);
    chk("t4_d0_drop", i0.drop_err, 0);
    rdy2 = 1'b1; tick();
    chk("t4_d2_second", i2.result, 2);
    tick(); rdy2 = 1'b0;
    chk("t4_d2_empty", i2.result_valid, 0);
    chk("t4_d2_drop_sticky", i2.drop_err, 1);

    // push on full with a simultaneous pop is accepted
    do_reset();
    beat(1, 1, pk(1, 0, 0, 0), pk(1, 0, 0, 0));
    beat(1, 1, pk(2, 0, 0, 0), pk(1, 0, 0, 0));
    beat(1, 1, pk(3, 0, 0, 0), pk(1, 0, 0, 0));
    tick();
    chk("t4b_full", i2.fifo_level, 2);
    rdy2 = 1'b1; tick(); rdy2 = 1'b0;
    chk("t4b_level", i2.fifo_level, 2);
    chk("t4b_drop", i2.drop_err, 0);
    chk("t4b_head", i2.result, 2);
    rdy2 = 1'b1; tick(); rdy2 = 1'b0;
    chk("t4b_tail", i2.result, 3);

    // OWIDTH=16 overflow: saturate or wrap depending on build
    do_reset();
    beat(1, 1, pk(127, 127, 127, 127), pk(127, 127, 127, 127));
    tick(); tick();
`ifdef MVM_ACC_SAT_EN
    chk("t5_d16", i16.result, 32767);
`else
    chk("t5_d16", i16.result, -1020);
`endif
    chk("t5_d0_wide", i0.result, 64516);

    // async reset mid-row discards partial sum and FIFO contents
    do_reset();
    beat(1, 1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    tick(); tick();
    chk("t6_pre_level", i0.fifo_level, 1);
    beat(1, 0, pk(1, 2, 3, 4), pk(2, 2, 2, 2));
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_level", i0.fifo_level, 0);
    chk("t6_rst_valid", i0.result_valid, 0);
    chk("t6_rst_busy", i0.busy, 0);
    tick();
    rst = 1'b0;
    beat(0, 1, pk(1, 1, 1, 1), pk(1, 2, 0, 3));
    beat(1, 1, pk(1, 2, 3, 4), pk(1, 1, 1, 1));
    tick();
    chk("t6_nofirst", i0.result, 6);
    tick();
    chk("t6_level", i0.fifo_level, 2);
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    chk("t6_result", i0.result, 10);
    chk("t6_drop", i0.drop_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
